compare_8bit: RTL and testbench
===============================

Name:
compare_8bit

Overview:
- Magnitude/equality comparator for two unsigned WIDTH-bit operands; default WIDTH is 8.
- Produces a zero-latency combinational equality flag, plus registered equal/greater/less flags one clock later.
- Adds an equality rising-edge pulse and a saturating match-cycle counter for monitoring.
- Used as a leaf utility wherever datapaths need operand-match detection.

Parameters:
- WIDTH, 8: operand width in bits; legal range 1..32.
- CNT_W, 16: width of the match counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- equal  output  1  combinational: 1 when a == b, else 0.
- eq_q  output  1  registered equal.
- gt_q  output  1  registered (a > b).
- lt_q  output  1  registered (a < b).
- eq_rise  output  1  one-cycle pulse when eq_q goes 0->1.
- match_cnt  output  CNT_W  number of clock cycles in which equal was 1 at the sampling edge; saturating.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). There are no asynchronous paths into the state.
- equal:
  - Purely combinational with zero latency, and is not affected by rst.
  - Depends on every bit of a and b.
  - Defined for all input values, including 0 == 0 -> 1.
- Comparison is unsigned across the full WIDTH bits. The combinational relations are mutually exclusive and exactly one holds: eq = (a==b), gt = (a>b), lt = (a<b).
- Registered flags:
  - On each rising edge with rst=0: eq_q <= eq, gt_q <= gt, lt_q <= lt.
  - Latency is 1 cycle. At all times after reset exactly one of eq_q/gt_q/lt_q is 1.
- eq_rise:
  - Registered. On each edge with rst=0: eq_rise <= eq & ~eq_q (current comparison equal, previous registered flag not equal).
  - It is high for exactly one cycle per 0->1 transition of eq_q, coincident with the first cycle eq_q is 1.
- match_cnt:
  - On each edge with rst=0, if eq=1 and match_cnt != all-ones, then match_cnt <= match_cnt + 1.
  - It holds at all-ones (saturates); there is no wrap-around.
- Reset, with rst=1 at an edge:
  - eq_q=0, gt_q=0, lt_q=0, eq_rise=0, match_cnt=0.
  - The comparison inputs are ignored for state on that edge.
  - This is the only cycle-window in which all three flags are 0.
- Reset mid-operation: state clears on the next edge regardless of the inputs. On the first edge after rst deasserts, the flags reflect the inputs at that edge. eq_rise may fire on that edge if a==b, because eq_q was 0.
- Input changes between edges affect only equal; registered outputs follow at the next edge.
- No X propagation requirement beyond standard RTL; inputs are assumed driven.

Test Plan:
- a=0,b=0 with no clock edges -> equal=1 immediately. Then a=100,b=99 -> equal=0 within the same timestep, and after 1 edge gt_q=1, eq_q=0, lt_q=0.
- a=100,b=100 -> equal=1. After edge: eq_q=1, eq_rise=1 for one cycle, match_cnt increments by 1 per edge while held.
- a=99,b=100 -> equal=0. After edge: lt_q=1, eq_q=0, eq_rise=0, match_cnt held.
- Extremes: a=255,b=0 -> gt_q=1; a=0,b=255 -> lt_q=1; a=255,b=255 -> eq_q=1 (checks that all 8 bits are compared).
- Reset: a=b=5 for 10 edges (match_cnt=10), then rst=1 for 1 edge -> all registered outputs 0 while equal stays 1. Release rst -> eq_q=1 and eq_rise=1 on the next edge, match_cnt=1.
- Saturation with CNT_W=4: hold a==b for 20 edges -> match_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/compare_8bit.sv
// Unsigned magnitude/equality comparator: combinational equal flag, registered
// eq/gt/lt flags, equality rising-edge pulse and a saturating match counter.
module compare_8bit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             equal,
   output logic             eq_q,
   output logic             gt_q,
   output logic             lt_q,
   output logic             eq_rise,
   output logic [CNT_W-1:0] match_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic eq_c;
   logic gt_c;
   logic lt_c;

   // Exactly one of these holds for any operand pair.
   always_comb begin
      eq_c = (a == b);
      gt_c = (a > b);
      lt_c = (a < b);
   end

   assign equal = eq_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         eq_rise   <= 1'b0;
         match_cnt <= '0;
      end else begin
         eq_q    <= eq_c;
         gt_q    <= gt_c;
         lt_q    <= lt_c;
         eq_rise <= eq_c & ~eq_q;
         // Counter saturates at all-ones instead of wrapping.
         if (eq_c && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_compare_8bit.sv
// Self-checking bench for compare_8bit: directed steps plus random stimulus
// against an arithmetic reference model; a second instance uses a 4-bit counter.
module tb_compare_8bit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;

   logic        equal, eq_q, gt_q, lt_q, eq_rise;
   logic [15:0] match_cnt;
   logic        equal4, eq_q4, gt_q4, lt_q4, eq_rise4;
   logic [3:0]  match_cnt4;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   logic m_eq, m_gt, m_lt, m_rise;
   int   m_matches;

   always #5 clk = ~clk;

   compare_8bit #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .equal(equal), .eq_q(eq_q), .gt_q(gt_q), .lt_q(lt_q),
      .eq_rise(eq_rise), .match_cnt(match_cnt)
   );

   compare_8bit #(.WIDTH(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .equal(equal4), .eq_q(eq_q4), .gt_q(gt_q4), .lt_q(lt_q4),
      .eq_rise(eq_rise4), .match_cnt(match_cnt4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   // Drive one cycle: set inputs, check combinational flag, clock, check state.
   task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic nr);
      int ia, ib;
      a = na;
      b = nb;
      rst = nr;
      ia = int'(na);
      ib = int'(nb);
      #1;
      check("equal", 32'(equal), 32'(ia == ib));
      check("equal4", 32'(equal4), 32'(ia == ib));
      @(posedge clk);
      if (nr) begin
         m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0; m_rise = 1'b0;
         m_matches = 0;
      end else begin
         m_rise = (ia == ib) && !m_eq;
         m_eq = (ia == ib);
         m_gt = (ia > ib);
         m_lt = (ia < ib);
         m_matches++;
         if (ia != ib) m_matches--;
      end
      #1;
      check("eq_q", 32'(eq_q), 32'(m_eq));
      check("gt_q", 32'(gt_q), 32'(m_gt));
      check("lt_q", 32'(lt_q), 32'(m_lt));
      check("eq_rise", 32'(eq_rise), 32'(m_rise));
      check("match_cnt", 32'(match_cnt), 32'(sat(m_matches, 16)));
      check("match_cnt4", 32'(match_cnt4), 32'(sat(m_matches, 4)));
      check("eq_rise4", 32'(eq_rise4), 32'(m_rise));
      if (!nr) check("one_hot", 32'(eq_q + gt_q + lt_q), 32'd1);
   endtask

   initial begin
      logic [7:0] ra, rb;
      m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0; m_rise = 1'b0;
      m_matches = 0;

      // Combinational flag before any clock edge
      a = 8'd0; b = 8'd0;
      #1;
      check("equal_at_t0", 32'(equal), 32'd1);
      a = 8'd100; b = 8'd99;
      #0;
      check("equal_same_step", 32'(equal), 32'd0);
      @(posedge clk);
      #1;

      step(8'd0, 8'd0, 1'b1);
      step(8'd0, 8'd0, 1'b1);

      step(8'd100, 8'd99, 1'b0);
      repeat (3) step(8'd100, 8'd100, 1'b0);
      step(8'd99, 8'd100, 1'b0);
      step(8'd255, 8'd0, 1'b0);
      step(8'd0, 8'd255, 1'b0);
      step(8'd255, 8'd255, 1'b0);
      step(8'd128, 8'd127, 1'b0);
      step(8'd1, 8'd0, 1'b0);

      // Reset mid-operation while operands stay equal
      step(8'd5, 8'd5, 1'b1);
      repeat (10) step(8'd5, 8'd5, 1'b0);
      check("match_cnt_10", 32'(match_cnt), 32'd10);
      step(8'd5, 8'd5, 1'b1);
      check("equal_in_reset", 32'(equal), 32'd1);
      step(8'd5, 8'd5, 1'b0);
      check("rise_after_reset", 32'(eq_rise), 32'd1);
      check("cnt_after_reset", 32'(match_cnt), 32'd1);

      // Saturation of the narrow counter
      repeat (20) step(8'd42, 8'd42, 1'b0);
      check("cnt4_saturated", 32'(match_cnt4), 32'd15);
      check("cnt16_running", 32'(match_cnt), 32'd21);

      // Random operands with frequent equality and occasional reset
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
         step(ra, rb, ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
